fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of each requester data word and of the FIFO write data.
REQ-002 Parameter BURST_LEN, default 4, maximum words written per grant; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port req  input  4  per-requester write request; requester i holds req[i] and its data stable until acked.
REQ-006 Port req_data  input  4*DATA_W  concatenated data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 Port gnt  output  4  registered one-hot grant, all-zero when no owner.
REQ-008 Port ack  output  4  combinational per-requester word-accepted strobe.
REQ-009 Port fifo_full  input  1  full flag from the 32-deep FIFO.
REQ-010 Port fifo_empty  input  1  empty flag from the FIFO.
REQ-011 Port fifo_wr_en  output  1  FIFO write enable.
REQ-012 Port fifo_data_in  output  DATA_W  FIFO write data.
REQ-013 Port cons_rd_req  input  1  consumer read request.
REQ-014 Port fifo_rd_en  output  1  FIFO read enable.
REQ-015 Port level  output  6  registered FIFO occupancy mirror, 0..32.

Function
REQ-016 The block SHALL implement a two-state FSM, IDLE and BURST, plus a 2-bit last-owner register and a 4-bit burst counter.
REQ-017 In IDLE with any req bit set and fifo_full low, the block SHALL select the first set req bit searching upward from (last_owner+1) mod 4, load gnt with that one-hot value, clear the burst counter and enter BURST on the next edge.
REQ-018 In IDLE with fifo_full high, the block SHALL issue no grant and SHALL remain in IDLE.
REQ-019 In BURST, ack[i] SHALL equal gnt[i] & req[i] & !fifo_full; fifo_wr_en SHALL equal the OR of ack; fifo_data_in SHALL equal the owner's req_data slice in the same cycle.
REQ-020 fifo_data_in SHALL be all-zero whenever fifo_wr_en is low.
REQ-021 Each cycle with fifo_wr_en high SHALL increment the burst counter by 1.
REQ-022 BURST SHALL return to IDLE, clear gnt and set last_owner to the current owner on the edge where the write brings the burst count to BURST_LEN, or on any edge where the owner's req is low.
REQ-023 fifo_full high during BURST SHALL stall the burst (no ack, counter held, grant held) with no timeout.
REQ-024 Grant is never pre-empted by a higher-priority requester; at most one ack bit SHALL be high in any cycle.
REQ-025 fifo_rd_en SHALL equal cons_rd_req & !fifo_empty, combinationally.
REQ-026 level SHALL increment by 1 on a write-only cycle, decrement by 1 on a read-only cycle, and hold when both or neither occur.
REQ-027 level SHALL saturate at 32 and 0 and never wrap.
REQ-028 A new grant SHALL NOT be issued in the same cycle a burst ends, so there is exactly one IDLE cycle between bursts.

Reset
REQ-029 While rst is high: state SHALL be IDLE, gnt SHALL be 0, burst counter SHALL be 0, level SHALL be 0, and last_owner SHALL be 3 so that requester 0 has first priority.
REQ-030 Assertion of rst mid-burst SHALL clear all state immediately, regardless of clk, and SHALL produce no further ack or fifo_wr_en.
REQ-031 Combinational outputs (ack, fifo_wr_en, fifo_rd_en) SHALL be 0 during reset, given gnt is 0 and the FIFO reports empty.

Verification
REQ-032 After reset, req=4'b1111 held, FIFO never full -> grants in order 0,1,2,3,0; each grant yields exactly 4 consecutive writes; one idle cycle between grants.
REQ-033 gnt=4'b0010 mid-burst after 2 writes, fifo_full asserted 3 cycles -> no ack for 3 cycles, gnt stays 4'b0010, then 2 more writes and release.
REQ-034 req[2] drops after 1 write -> release on that edge; last_owner=2; next grant goes to requester 3 if requesting, else 0.
REQ-035 Write-only cycles until level=32 with fifo_full high -> level holds at 32; IDLE issues no grant; a simultaneous read and write leaves level unchanged.
REQ-036 cons_rd_req=1 with fifo_empty=1 -> fifo_rd_en=0 and level stays 0.
REQ-037 rst pulsed asynchronously between edges during BURST -> gnt=0, level=0, fifo_wr_en=0 immediately; after release, requester 0 wins first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter feeding four requesters into one
// write port of a 32-deep FIFO, plus a registered occupancy mirror.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin when the FIFO has room
// BURST | one requester owns the write port for up to BURST_LEN words
module fifo_wr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          gnt,
  output logic [3:0]          ack,
  input  logic                fifo_full,
  input  logic                fifo_empty,
  output logic                fifo_wr_en,
  output logic [DATA_W-1:0]   fifo_data_in,
  input  logic                cons_rd_req,
  output logic                fifo_rd_en,
  output logic [5:0]          level
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [3:0] LEN_M1  = 4'(BURST_LEN - 1);
  localparam logic [5:0] LVL_MAX = 6'd32;

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [3:0] burst_cnt, burst_cnt_nxt;
  logic [1:0] last_owner, last_owner_nxt;
  logic [1:0] owner;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       pick_vld;

  // Index of the current owner, decoded from the one-hot grant.
  always_comb begin
    owner = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) owner = 2'(i);
    end
  end

  // Round-robin search starting just above the last owner.
  always_comb begin
    pick     = 2'd0;
    pick_vld = 1'b0;
    idx      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_owner + 2'(k);
      if (!pick_vld && req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Write-port strobes and data; data is forced to zero when no write occurs.
  always_comb begin
    ack          = 4'b0000;
    if (state == BURST && !fifo_full) ack = gnt & req;
    fifo_wr_en   = |ack;
    fifo_data_in = '0;
    if (fifo_wr_en) fifo_data_in = req_data[32'(owner)*DATA_W +: DATA_W];
    fifo_rd_en   = cons_rd_req & ~fifo_empty;
  end

  // Next-state logic: grant from IDLE, release on burst length or dropped req.
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    burst_cnt_nxt  = burst_cnt;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (pick_vld && !fifo_full) begin
          state_nxt     = BURST;
          gnt_nxt       = 4'b0001 << pick;
          burst_cnt_nxt = 4'd0;
        end
      end
      BURST: begin
        if (!req[owner]) begin
          state_nxt      = IDLE;
          gnt_nxt        = 4'b0000;
          last_owner_nxt = owner;
        end else if (fifo_wr_en) begin
          burst_cnt_nxt = burst_cnt + 4'd1;
          if (burst_cnt == LEN_M1) begin
            state_nxt      = IDLE;
            gnt_nxt        = 4'b0000;
            last_owner_nxt = owner;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  // Arbiter state registers; last_owner resets to 3 so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 4'b0000;
      burst_cnt  <= 4'd0;
      last_owner <= 2'd3;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      burst_cnt  <= burst_cnt_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Occupancy mirror, saturating at 0 and 32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 6'd0;
    end else if (fifo_wr_en && !fifo_rd_en) begin
      if (level != LVL_MAX) level <= level + 6'd1;
    end else if (fifo_rd_en && !fifo_wr_en) begin
      if (level != 6'd0) level <= level - 6'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: the driver runs a behavioural model
// and queues the expected outputs of every cycle; the monitor pops and compares.
module tb_fifo_wr_arbiter;

  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;

  logic                clk;
  logic                rst;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          gnt;
  logic [3:0]          ack;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_wr_en;
  logic [DATA_W-1:0]   fifo_data_in;
  logic                cons_rd_req;
  logic                fifo_rd_en;
  logic [5:0]          level;

  fifo_wr_arbiter #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_wr_en(fifo_wr_en),
    .fifo_data_in(fifo_data_in), .cons_rd_req(cons_rd_req),
    .fifo_rd_en(fifo_rd_en), .level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [3:0]        gnt;
    logic [3:0]        ack;
    logic              wr;
    logic [DATA_W-1:0] data;
    logic              rd;
    logic [5:0]        level;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Reference model: owner index (-1 = none), words in burst, last owner, occupancy.
  int                m_owner, m_cnt, m_last, m_level;
  logic [3:0]        prev_ack;
  logic [DATA_W-1:0] words [4];
  logic [3:0]        rq;

  function automatic void chk(string name, int c, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
    end
  endfunction

  function automatic void model_reset();
    m_owner  = -1;
    m_cnt    = 0;
    m_last   = 3;
    m_level  = 0;
    prev_ack = 4'b0000;
  endfunction

  task automatic step(input logic [3:0] r, input logic full, input logic empty,
                      input logic cons);
    exp_t e;
    int   k, idx;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (prev_ack[i]) words[i] = $urandom;
    req         = r;
    fifo_full   = full;
    fifo_empty  = empty;
    cons_rd_req = cons;
    for (int i = 0; i < 4; i++) req_data[i*DATA_W +: DATA_W] = words[i];

    e.cyc   = cyc;
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e.ack   = (m_owner >= 0 && r[m_owner] && !full) ? 4'(1 << m_owner) : 4'b0000;
    e.wr    = (e.ack != 4'b0000);
    e.data  = e.wr ? words[m_owner] : '0;
    e.rd    = cons && !empty;
    e.level = 6'(m_level);
    sb.push_back(e);
    prev_ack = e.ack;

    if (m_owner < 0) begin
      if (r != 4'b0000 && !full) begin
        idx = -1;
        for (k = 1; k <= 4; k++) begin
          if (idx < 0 && r[(m_last + k) % 4]) idx = (m_last + k) % 4;
        end
        m_owner = idx;
        m_cnt   = 0;
      end
    end else if (!r[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (e.wr) begin
      m_cnt++;
      if (m_cnt == BURST_LEN) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    if (e.wr && !e.rd) m_level = (m_level < 32) ? m_level + 1 : 32;
    else if (e.rd && !e.wr) m_level = (m_level > 0) ? m_level - 1 : 0;
    cyc++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req = 4'b0000;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt",   e.cyc, 64'(gnt),          64'(e.gnt));
      chk("ack",   e.cyc, 64'(ack),          64'(e.ack));
      chk("wr_en", e.cyc, 64'(fifo_wr_en),   64'(e.wr));
      chk("data",  e.cyc, 64'(fifo_data_in), 64'(e.data));
      chk("rd_en", e.cyc, 64'(fifo_rd_en),   64'(e.rd));
      chk("level", e.cyc, 64'(level),        64'(e.level));
    end
  end

  initial begin
    rst         = 1'b1;
    req         = 4'b1111;
    req_data    = '0;
    fifo_full   = 1'b0;
    fifo_empty  = 1'b1;
    cons_rd_req = 1'b1;
    for (int i = 0; i < 4; i++) words[i] = $urandom;
    model_reset();

    // Outputs during reset with requests pending and an empty FIFO.
    #12;
    chk("rst_gnt",   -1, 64'(gnt),        64'h0);
    chk("rst_ack",   -1, 64'(ack),        64'h0);
    chk("rst_wr_en", -1, 64'(fifo_wr_en), 64'h0);
    chk("rst_rd_en", -1, 64'(fifo_rd_en), 64'h0);
    chk("rst_level", -1, 64'(level),      64'h0);
    req         = 4'b0000;
    cons_rd_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All requesting, FIFO never full: 0,1,2,3,0 with 4-word bursts.
    for (int i = 0; i < 22; i++) step(4'b1111, 1'b0, 1'b1, 1'b0);

    // Stall mid-burst: 2 writes, 3 full cycles, 2 more writes then release.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0010, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0010, 1'b0, 1'b1, 1'b0);

    // Early release by requester 2, then 3 beats 0 on the next grant.
    do_reset();
    step(4'b0100, 1'b0, 1'b1, 1'b0);
    step(4'b0100, 1'b0, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b1001, 1'b0, 1'b1, 1'b0);

    // Read request against an empty FIFO.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b1, 1'b1);

    // Fill to saturation, hold off grants while full, then read and write together.
    for (int i = 0; i < 50; i++) step(4'b1111, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8;  i++) step(4'b1111, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(4'b1111, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset between edges while a burst is in progress.
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("arst_gnt",   cyc, 64'(gnt),        64'h0);
    chk("arst_level", cyc, 64'(level),      64'h0);
    chk("arst_wr_en", cyc, 64'(fifo_wr_en), 64'h0);
    chk("arst_ack",   cyc, 64'(ack),        64'h0);
    @(posedge clk);
    #1;
    req = 4'b0000;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b1, 1'b0);

    // Randomised traffic with protocol-respecting requesters.
    rq = 4'b0000;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (prev_ack[i]) begin
          if ($urandom_range(3) == 0) rq[i] = 1'b0;
        end else if (!rq[i] && $urandom_range(2) == 0) begin
          rq[i]    = 1'b1;
          words[i] = $urandom;
        end
      end
      step(rq, ($urandom_range(4) == 0), ($urandom_range(3) == 0), 1'($urandom_range(1)));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
